exec_stage: RTL
===============

# exec_stage

Execute stage of the datapath, sitting directly downstream of the A/B operand pipeline registers and upstream of the C result pipeline register. It takes two 16-bit operands, applies an optional shift to operand B, and computes an ALU result and status flags. Single-cycle ALU ops complete one cycle after issue. MUL runs a 16-iteration shift-add sequence. On completion the stage presents a registered result with a one-cycle `loadc` pulse that the C pipeline register uses as its load.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width; the design is verified only at 16.

Ports:
- `clk` in 1: rising-edge clock; the single clock of the block.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: issue request; accepted only on a rising edge where `ready`=1.
- `a_in` in 16: operand A, from the A pipeline register.
- `b_in` in 16: operand B, from the B pipeline register.
- `imm` in 16: sign-extended immediate.
- `asel` in 1: 1 = operand A forced to 0x0000.
- `bsel` in 1: 1 = operand B taken from `imm` instead of `b_in`, before the shifter.
- `shift` in 2: 00 = none, 01 = LSL1, 10 = LSR1 (zero fill), 11 = ASR1 (sign fill); applied to the selected B.
- `alu_op` in 3: 000 ADD, 001 SUB (A−B), 010 AND, 011 MVN (~B), 100 MUL (low 16 bits, unsigned); 101–111 reserved, result 0x0000.
- `ready` out 1: 1 when idle and able to accept `start`.
- `loadc` out 1: one-cycle completion pulse; load enable for the C pipeline register.
- `result` out 16: registered result; held until the next completion.
- `status` out 3: registered {V,N,Z}; updated only on completion.

## Operation
- States: IDLE and MUL. `ready` = (state == IDLE).
- All inputs are sampled on the accepting edge only. Later changes to the inputs do not affect an operation in flight.
- Non-MUL op accepted at edge k:
  - `result`/`status` are written at edge k.
  - `loadc`=1 for the cycle following edge k.
  - The state stays IDLE, so back-to-back issue every cycle is allowed.
- MUL accepted at edge k:
  - Capture the multiplicand (A) and multiplier (shifted B), clear a 32-bit accumulator and a 4-bit counter, then enter MUL.
  - Each edge in MUL: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; increment the counter.
  - At the 16th iteration edge (k+16): write `result`/`status`, return to IDLE, and assert `loadc` for the following cycle.
- `start` while `ready`=0 is ignored; it is neither queued nor does it corrupt the operation in flight.
- Status flags:
  - Z: result == 0.
  - N: result[15].
  - V for ADD: operand signs equal and result sign differs.
  - V for SUB: operand signs differ and result sign differs from A.
  - V for MUL: product[31:16] != 0.
  - V for AND/MVN/reserved: 0.
- Arithmetic is modulo 2^16. Carry out is discarded and no carry flag exists.
- LSL1 and LSR1 discard the shifted-out bit. ASR1 of 0xFFFF = 0xFFFF.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE, `ready`=1, `loadc`=0;
  - `result`=0x0000, `status`=3'b000;
  - accumulator and counter cleared.
- Reset in mid-MUL aborts the multiply. No `loadc` is produced for the aborted op; the first legal issue is on the first rising edge after `rst_n` returns high.
- Latency:
  - non-MUL: 1 edge (result visible the cycle after issue);
  - MUL: 16 edges after the accepting edge; `ready`=0 for cycles k+1 … k+16.
- `loadc` is high for exactly one cycle per completed op and is never high two cycles in a row for a MUL.
- A new `start` on the same edge MUL completes (`ready`=0) is ignored. The earliest reissue is the edge after `ready` returns to 1.
- `result` and `status` change only on completion edges or reset.

## Test plan
- ADD overflow: a=0x7FFF, b=0x0001, shift=00, ADD → next cycle `result`=0x8000, `status`={1,1,0}, `loadc`=1 for one cycle.
- SUB zero + immediate: a=0x0005, imm=0x0005, bsel=1, SUB → `result`=0x0000, `status`={0,0,1}.
- Shifter/asel: asel=1, b=0x8001, shift=11, ADD → `result`=0xC000, N=1. The same with shift=10 → 0x4000. With shift=01 → 0x0002.
- MUL: a=300, b=200, MUL → `ready`=0 for 16 cycles; `loadc` once at cycle 17 with `result`=0xEA60, `status`={0,1,0}. a=0x0100, b=0x0100 → `result`=0x0000, `status`={1,0,1}.
- Busy/back-to-back: issue MUL, then pulse `start` with ADD on cycles 3 and 16 → both ignored, only one `loadc`. ADD issued every cycle for 4 cycles → 4 consecutive `loadc` pulses with correct results.
- Reset mid-MUL: assert `rst_n`=0 at iteration 8 → `ready`=1, `loadc`=0, `result`=0x0000, `status`=0 immediately; no stray `loadc` after release; a subsequent ADD 2+3 → 0x0005.

Source files
------------

// File: rtl/exec_stage.sv
// Execute stage: operand select, single-bit shifter, ALU with {V,N,Z}
// status, and a 16-iteration shift-add multiplier. Results are registered
// and announced with a one-cycle loadc pulse for the C pipeline register.
module exec_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] imm,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       shift,
  input  logic [2:0]       alu_op,
  output logic             ready,
  output logic             loadc,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_MVN = 3'b011,
    OP_MUL = 3'b100
  } op_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         status_q, status_d;
  logic               loadc_q, loadc_d;

  logic [WIDTH-1:0]   opa, opb_sel, opb;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_step;

  // Operand A forcing, operand B source select, then the B shifter.
  always_comb begin
    opa     = asel ? '0 : a_in;
    opb_sel = bsel ? imm : b_in;
    unique case (shift)
      2'b01:   opb = {opb_sel[WIDTH-2:0], 1'b0};
      2'b10:   opb = {1'b0, opb_sel[WIDTH-1:1]};
      2'b11:   opb = {opb_sel[WIDTH-1], opb_sel[WIDTH-1:1]};
      default: opb = opb_sel;
    endcase
  end

  // Single-cycle ALU result and overflow flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned (no latch).
    alu_res = '0;
    alu_v   = 1'b0;
    case (op_e'(alu_op))
      OP_ADD: begin
        alu_res = opa + opb;
        alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = opa - opb;
        alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_MVN:  alu_res = ~opb;
      default: alu_res = '0;  // MUL is handled by the sequencer; reserved ops give zero
    endcase
  end

  // One shift-add iteration: accumulate the multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state, issue acceptance, multiply sequencing and completion.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    status_d = status_q;
    loadc_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_e'(alu_op) == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, opa};
            mplier_d = opb;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            status_d = {alu_v, alu_res[WIDTH-1], alu_res == '0};
            loadc_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = acc_step[WIDTH-1:0];
          status_d = {|acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0};
          loadc_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop here is reset, including the multiply working
    // registers, so an aborted multiply leaves no stale state behind.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      status_q <= '0;
      loadc_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      status_q <= status_d;
      loadc_q  <= loadc_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign loadc  = loadc_q;
  assign result = result_q;
  assign status = status_q;

endmodule
